// File: rtl/command_fetcher.sv
// Command-list prefetch buffer: burst-reads BUFFER_DEPTH consecutive words from main
// memory into a local buffer, then presents any buffered word by index.
//
// state | meaning
// IDLE  | waiting for anExecute, no memory traffic
// FETCH | issuing addresses base..base+N-1, capturing returned words one cycle later
// READY | buffer holds a complete list, waiting for restart
module command_fetcher #(
    parameter int MAIN_MEMORY_BUS_ADDR_WIDTH = 32,
    parameter int MAIN_MEMORY_BUS_DEPTH      = 32,
    parameter int BUFFER_DEPTH               = 64
) (
    input  logic                                  aClock,
    input  logic                                  aReset,
    input  logic [MAIN_MEMORY_BUS_ADDR_WIDTH-1:0] aCommandPointer,
    input  logic                                  anExecute,
    output logic [MAIN_MEMORY_BUS_ADDR_WIDTH-1:0] anOutMemoryAddr,
    input  logic [MAIN_MEMORY_BUS_DEPTH-1:0]      aMemoryData,
    output logic                                  anOutMemoryEnable,
    input  logic [$clog2(BUFFER_DEPTH)-1:0]       aCommandIndex,
    output logic [MAIN_MEMORY_BUS_DEPTH-1:0]      aCommandData,
    input  logic                                  aCommandRead,
    output logic                                  anOutReady
);

    localparam int INDEX_WIDTH = $clog2(BUFFER_DEPTH);
    localparam int ISSUE_WIDTH = INDEX_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } FetchState;

    FetchState                             state          = IDLE;
    logic [MAIN_MEMORY_BUS_ADDR_WIDTH-1:0] base           = '0;
    logic [MAIN_MEMORY_BUS_ADDR_WIDTH-1:0] memoryAddr     = '0;
    logic                                  memoryEnable   = 1'b0;
    logic                                  ready          = 1'b0;
    logic [ISSUE_WIDTH-1:0]                issueCount     = '0;
    logic [INDEX_WIDTH-1:0]                captureCount   = '0;
    logic                                  capturePending = 1'b0;
    logic [MAIN_MEMORY_BUS_DEPTH-1:0]      commandBuffer [BUFFER_DEPTH] = '{default: '0};

    // Consume strobe is reserved and intentionally has no effect.
    logic unusedCommandRead;
    assign unusedCommandRead = aCommandRead;

    assign anOutMemoryAddr   = memoryAddr;
    assign anOutMemoryEnable = memoryEnable;
    assign anOutReady        = ready;
    assign aCommandData      = commandBuffer[aCommandIndex];

    always_ff @(posedge aClock) begin
        if (aReset) begin
            state          <= IDLE;
            base           <= '0;
            memoryAddr     <= '0;
            memoryEnable   <= 1'b0;
            ready          <= 1'b0;
            issueCount     <= '0;
            captureCount   <= '0;
            capturePending <= 1'b0;
        end else begin
            capturePending <= memoryEnable;
            case (state)
                IDLE, READY: begin
                    // The start edge itself issues word 0, so the issue count starts at 1.
                    if (anExecute) begin
                        base         <= aCommandPointer;
                        memoryAddr   <= aCommandPointer;
                        memoryEnable <= 1'b1;
                        issueCount   <= ISSUE_WIDTH'(1);
                        captureCount <= '0;
                        ready        <= 1'b0;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (issueCount == ISSUE_WIDTH'(BUFFER_DEPTH)) begin
                        memoryEnable <= 1'b0;
                    end else begin
                        memoryAddr <= base + MAIN_MEMORY_BUS_ADDR_WIDTH'(issueCount);
                        issueCount <= issueCount + ISSUE_WIDTH'(1);
                    end
                    if (capturePending) begin
                        captureCount <= captureCount + INDEX_WIDTH'(1);
                        if (captureCount == INDEX_WIDTH'(BUFFER_DEPTH - 1)) begin
                            ready <= 1'b1;
                            state <= READY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer has no reset: contents survive aReset.
    always_ff @(posedge aClock) begin
        if (!aReset && capturePending) begin
            commandBuffer[captureCount] <= aMemoryData;
        end
    end

endmodule

// File: tb/tb_command_fetcher.sv
// Directed bench for command_fetcher: 1-cycle-latency memory model, fetch timing,
// wrap-around, ignored mid-fetch inputs, restart and reset abort.
module tb_command_fetcher;

    logic        aClock = 1'b0;
    logic        aReset = 1'b0;
    logic [31:0] aCommandPointer = '0;
    logic        anExecute = 1'b0;
    logic [31:0] anOutMemoryAddr;
    logic [31:0] aMemoryData = '0;
    logic        anOutMemoryEnable;
    logic [5:0]  aCommandIndex = '0;
    logic [31:0] aCommandData;
    logic        aCommandRead = 1'b0;
    logic        anOutReady;

    int passCount  = 0;
    int checkCount = 0;

    command_fetcher dut (
        .aClock            (aClock),
        .aReset            (aReset),
        .aCommandPointer   (aCommandPointer),
        .anExecute         (anExecute),
        .anOutMemoryAddr   (anOutMemoryAddr),
        .aMemoryData       (aMemoryData),
        .anOutMemoryEnable (anOutMemoryEnable),
        .aCommandIndex     (aCommandIndex),
        .aCommandData      (aCommandData),
        .aCommandRead      (aCommandRead),
        .anOutReady        (anOutReady)
    );

    always #5 aClock = ~aClock;

    // mem[a] = 0xA000_0000 + a, one cycle read latency
    always @(posedge aClock) begin
        if (anOutMemoryEnable) aMemoryData <= 32'hA000_0000 + anOutMemoryAddr;
    end

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic checkBuffer(input logic [5:0] index, input logic [31:0] expected);
        aCommandIndex = index;
        #1;
        checkValue($sformatf("buffer[%0d]", index), aCommandData, expected);
    endtask

    // Starts a fetch from a negedge and walks cycles 1..66 after the start edge.
    // With disturb set, pointer and anExecute are changed mid-fetch.
    task automatic runFetch(input logic [31:0] base, input bit disturb);
        aCommandPointer = base;
        anExecute = 1'b1;
        @(posedge aClock);
        @(negedge aClock);
        anExecute = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            if (k <= 64) begin
                checkValue($sformatf("enable c%0d", k), {31'b0, anOutMemoryEnable}, 32'd1);
                checkValue($sformatf("addr c%0d", k), anOutMemoryAddr, base + 32'(k - 1));
            end else begin
                checkValue($sformatf("enable c%0d", k), {31'b0, anOutMemoryEnable}, 32'd0);
            end
            checkValue($sformatf("ready c%0d", k), {31'b0, anOutReady}, (k == 66) ? 32'd1 : 32'd0);
            if (disturb && k == 10) begin
                aCommandPointer = 32'hDEAD_0000;
                anExecute = 1'b1;
            end
            if (k == 11) anExecute = 1'b0;
            if (k < 66) @(negedge aClock);
        end
    endtask

    initial begin
        // Reset
        @(negedge aClock);
        aReset = 1'b1;
        repeat (2) @(negedge aClock);
        checkValue("reset ready", {31'b0, anOutReady}, 32'd0);
        checkValue("reset enable", {31'b0, anOutMemoryEnable}, 32'd0);
        checkValue("reset addr", anOutMemoryAddr, 32'd0);
        aReset = 1'b0;
        @(negedge aClock);

        // Basic fetch and full index sweep
        runFetch(32'h0000_0100, 1'b0);
        for (int i = 0; i < 64; i++) checkBuffer(6'(i), 32'hA000_0100 + 32'(i));

        // aCommandRead is reserved: no effect in READY
        aCommandIndex = 6'd5;
        for (int c = 0; c < 4; c++) begin
            aCommandRead = ~aCommandRead;
            @(negedge aClock);
            checkValue("read data", aCommandData, 32'hA000_0105);
            checkValue("read ready", {31'b0, anOutReady}, 32'd1);
        end
        aCommandRead = 1'b0;

        // Restart from READY with mid-fetch pointer change and execute pulse
        runFetch(32'h0000_0200, 1'b1);
        checkBuffer(6'd0, 32'hA000_0200);
        checkBuffer(6'd63, 32'hA000_023F);
        repeat (3) @(negedge aClock);
        checkValue("no restart ready", {31'b0, anOutReady}, 32'd1);
        checkValue("no restart enable", {31'b0, anOutMemoryEnable}, 32'd0);

        // Address wrap-around
        runFetch(32'hFFFF_FFFE, 1'b0);
        checkBuffer(6'd0, 32'h9FFF_FFFE);
        checkBuffer(6'd1, 32'h9FFF_FFFF);
        checkBuffer(6'd2, 32'hA000_0000);
        checkBuffer(6'd63, 32'hA000_003D);

        // Reset at issue 20 aborts the fetch
        aCommandPointer = 32'h0000_0400;
        anExecute = 1'b1;
        @(posedge aClock);
        @(negedge aClock);
        anExecute = 1'b0;
        repeat (20) @(negedge aClock);
        checkValue("pre-abort addr", anOutMemoryAddr, 32'h0000_0414);
        aReset = 1'b1;
        @(negedge aClock);
        aReset = 1'b0;
        checkValue("abort enable", {31'b0, anOutMemoryEnable}, 32'd0);
        checkValue("abort addr", anOutMemoryAddr, 32'd0);
        checkValue("abort ready", {31'b0, anOutReady}, 32'd0);
        repeat (70) @(negedge aClock);
        checkValue("idle ready", {31'b0, anOutReady}, 32'd0);
        checkValue("idle enable", {31'b0, anOutMemoryEnable}, 32'd0);

        // Fresh fetch after abort
        runFetch(32'h0000_0500, 1'b0);
        checkBuffer(6'd0, 32'hA000_0500);
        checkBuffer(6'd20, 32'hA000_0514);
        checkBuffer(6'd63, 32'hA000_053F);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
